// File: rtl/spi_interface_master.sv
// SPI master: runtime CPOL/CPHA/width, divided sck, start/finish handshake.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first bit order on mosi and miso.
module spi_interface_master #(
  parameter int SPI_MAX_WIDTH_LOG = 4,
  parameter int CLK_DIV_WIDTH     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            config_req,
  input  logic [SPI_MAX_WIDTH_LOG+1:0]    config_data,
  input  logic [CLK_DIV_WIDTH-1:0]        clk_div,
  input  logic                            start_req,
  input  logic [2**SPI_MAX_WIDTH_LOG-1:0] din,
  output logic                            busy,
  output logic                            spi_start,
  output logic                            spi_finish,
  output logic [2**SPI_MAX_WIDTH_LOG-1:0] dout,
  output logic                            sck,
  output logic                            cs,
  output logic                            mosi,
  input  logic                            miso
);

  localparam int LW = SPI_MAX_WIDTH_LOG;
  localparam int DW = 2**SPI_MAX_WIDTH_LOG;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [LW:0]              E_ONE = 1;
  localparam logic [LW-1:0]            B_ONE = 1;
  localparam logic [CLK_DIV_WIDTH-1:0] C_ONE = 1;

  logic [1:0]               state;
  logic                     cpol;
  logic                     cpha;
  logic [LW-1:0]            width;
  logic [CLK_DIV_WIDTH-1:0] div_r;
  logic [CLK_DIV_WIDTH-1:0] cnt;
  logic [LW:0]              ecnt;
  logic [DW-1:0]            tx;
  logic [DW-1:0]            rx;

  logic          idle_free;
  logic          cfg_load;
  logic          accept;
  logic          tick;
  logic          lead;
  logic          last;
  logic          do_drive;
  logic [LW-1:0] bit_idx;
  logic [LW-1:0] drv_idx;
  logic [LW-1:0] drv_pos;
  logic          first_bit;

  assign idle_free = (state == IDLE) && !busy;
  assign cfg_load  = idle_free && config_req;
  assign accept    = idle_free && start_req;
  assign tick      = (cnt == div_r);
  assign lead      = ~ecnt[0];
  assign bit_idx   = ecnt[LW:1];
  assign last      = (ecnt == {width, 1'b1});
  assign drv_idx   = cpha ? bit_idx : bit_idx + B_ONE;
  assign do_drive  = cpha ? lead : (!lead && bit_idx != width);

  // First bit uses the incoming config when it loads in the same cycle.
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign drv_pos   = drv_idx;
  assign first_bit = din[0];
`else
  logic [LW-1:0] eff_width;
  assign eff_width = cfg_load ? config_data[LW-1:0] : width;
  assign drv_pos   = width - drv_idx;
  assign first_bit = din[eff_width];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cpol       <= 1'b0;
      cpha       <= 1'b0;
      width      <= '1;
      div_r      <= '0;
      cnt        <= '0;
      ecnt       <= '0;
      tx         <= '0;
      rx         <= '0;
      busy       <= 1'b0;
      spi_start  <= 1'b0;
      spi_finish <= 1'b0;
      dout       <= '0;
      sck        <= 1'b0;
      cs         <= 1'b1;
      mosi       <= 1'b0;
    end else begin
      spi_start  <= 1'b0;
      spi_finish <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (cfg_load) begin
            cpol  <= config_data[LW+1];
            cpha  <= config_data[LW];
            width <= config_data[LW-1:0];
            sck   <= config_data[LW+1];
          end
          if (accept) begin
            state     <= SETUP;
            busy      <= 1'b1;
            spi_start <= 1'b1;
            cs        <= 1'b0;
            tx        <= din;
            div_r     <= clk_div;
            cnt       <= '0;
            ecnt      <= '0;
            rx        <= '0;
            mosi      <= first_bit;
          end
        end
        SETUP, XFER: begin
          if (tick) begin
            sck  <= ~sck;
            ecnt <= ecnt + E_ONE;
            cnt  <= '0;
            // Sample on leading edge for cpha=0, trailing for cpha=1.
            if (lead ^ cpha) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
              rx[bit_idx] <= miso;
`else
              rx <= {rx[DW-2:0], miso};
`endif
            end
            if (do_drive) mosi <= tx[drv_pos];
            state <= last ? HOLD : XFER;
          end else begin
            cnt <= cnt + C_ONE;
          end
        end
        HOLD: begin
          if (tick) begin
            cs         <= 1'b1;
            spi_finish <= 1'b1;
            dout       <= rx;
            cnt        <= '0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + C_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_interface_master.sv
// Scoreboard bench for spi_interface_master: directed frames,
// loopback or a small slave model on miso.
module tb_spi_interface_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        config_req;
  logic [5:0]  config_data;
  logic [7:0]  clk_div;
  logic        start_req;
  logic [15:0] din;
  logic        busy;
  logic        spi_start;
  logic        spi_finish;
  logic [15:0] dout;
  logic        sck;
  logic        cs;
  logic        mosi;
  logic        miso;

  always #5 clk = ~clk;

  spi_interface_master #(
    .SPI_MAX_WIDTH_LOG(4),
    .CLK_DIV_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .config_req(config_req),
    .config_data(config_data),
    .clk_div(clk_div),
    .start_req(start_req),
    .din(din),
    .busy(busy),
    .spi_start(spi_start),
    .spi_finish(spi_finish),
    .dout(dout),
    .sck(sck),
    .cs(cs),
    .mosi(mosi),
    .miso(miso)
  );

  typedef struct {
    logic [15:0] dout;
    int          edges;
    int          half;
  } exp_t;

  typedef struct {
    string       n;
    logic [31:0] a;
    logic [31:0] e;
  } probe_t;

  exp_t   sbq[$];
  probe_t pq[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;

  // Slave model: config as the bench believes it is.
  logic        loop;
  logic [15:0] slave_word;
  logic        tb_cpol;
  logic        tb_cpha;
  logic [3:0]  tb_w;
  logic        slave_bit;
  int          ec = 0;
  logic        sck_q = 1'b0;

  always @(sck or cs) begin
    if (cs) ec = 0;
    else if (sck !== sck_q) ec = ec + 1;
    sck_q = sck;
  end

  always @* begin
    int i;
    i = tb_cpha ? ((ec == 0) ? 0 : (ec - 1) / 2) : ec / 2;
    if (i > int'(tb_w)) i = int'(tb_w);
`ifdef SPI_MASTER_LSB_FIRST_EN
    slave_bit = slave_word[i];
`else
    slave_bit = slave_word[int'(tb_w) - i];
`endif
  end

  assign miso = loop ? mosi : slave_bit;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  int   f_edges, f_starts, last_ev, hp_min, hp_max, mosi_bad;
  logic prev_sck, prev_mosi, prev_cs;

  task automatic cmp(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    int   iv;
    exp_t x;
    while (pq.size() > 0) begin
      probe_t p;
      p = pq.pop_front();
      cmp(p.n, p.a, p.e);
    end
    if (rst) begin
      f_edges  = 0;
      f_starts = 0;
      mosi_bad = 0;
      hp_min   = 1000;
      hp_max   = 0;
      last_ev  = cyc;
    end else begin
      if (spi_start) begin
        f_starts++;
        f_edges  = 0;
        last_ev  = cyc;
        hp_min   = 1000;
        hp_max   = 0;
        mosi_bad = 0;
      end
      if (sck !== prev_sck && !cs) begin
        f_edges++;
        iv = cyc - last_ev;
        if (iv < hp_min) hp_min = iv;
        if (iv > hp_max) hp_max = iv;
        last_ev = cyc;
      end
      if (!cs && !prev_cs && mosi !== prev_mosi) begin
        if (!(sck !== prev_sck && sck === (tb_cpha ? ~tb_cpol : tb_cpol)))
          mosi_bad++;
      end
      if (spi_finish) begin
        iv = cyc - last_ev;
        if (iv < hp_min) hp_min = iv;
        if (iv > hp_max) hp_max = iv;
        if (sbq.size() == 0) begin
          cmp("unexpected_finish", 32'(done_cnt + 1), 32'(done_cnt));
        end else begin
          x = sbq.pop_front();
          cmp("dout", 32'(dout), 32'(x.dout));
          cmp("sck_edges", 32'(f_edges), 32'(x.edges));
          cmp("half_min", 32'(hp_min), 32'(x.half));
          cmp("half_max", 32'(hp_max), 32'(x.half));
          cmp("start_pulses", 32'(f_starts), 32'd1);
          cmp("mosi_edge", 32'(mosi_bad), 32'd0);
          cmp("cs_at_finish", 32'(cs), 32'd1);
        end
        done_cnt++;
        f_starts = 0;
      end
    end
    prev_sck  = sck;
    prev_mosi = mosi;
    prev_cs   = cs;
  end

  task automatic probe(string n, logic [31:0] a, logic [31:0] e);
    pq.push_back('{n, a, e});
  endtask

  function automatic logic first_of(logic [15:0] d);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return d[0];
`else
    return d[tb_w];
`endif
  endfunction

  task automatic configure(logic cp, logic ch, logic [3:0] w);
    @(posedge clk); #1;
    config_req  = 1'b1;
    config_data = {cp, ch, w};
    @(posedge clk); #1;
    config_req = 1'b0;
    tb_cpol = cp;
    tb_cpha = ch;
    tb_w    = w;
  endtask

  task automatic start_frame(string tag, logic [15:0] d,
                             logic [7:0] div, output int d0);
    @(posedge clk); #1;
    din       = d;
    clk_div   = div;
    start_req = 1'b1;
    d0        = done_cnt;
    @(posedge clk); #1;
    start_req = 1'b0;
    probe({tag, "_mosi_first"}, 32'(mosi), 32'(first_of(d)));
    probe({tag, "_busy"}, 32'(busy), 32'd1);
    probe({tag, "_cs_low"}, 32'(cs), 32'd0);
  endtask

  task automatic wait_done(int d0, int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == d0) probe("timeout", 32'(done_cnt), 32'(d0 + 1));
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(string tag, logic [15:0] d, logic [7:0] div,
                           logic [15:0] ed, int edges);
    int d0;
    sbq.push_back('{ed, edges, int'(div) + 1});
    start_frame(tag, d, div, d0);
    wait_done(d0, 4 * (edges + 4) * (int'(div) + 1) + 20);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   d0;
    int   n;
    logic ps;
    rst = 1'b1;
    config_req = 1'b0;
    config_data = '0;
    clk_div = '0;
    start_req = 1'b0;
    din = '0;
    loop = 1'b1;
    slave_word = '0;
    tb_cpol = 1'b0;
    tb_cpha = 1'b0;
    tb_w = 4'hf;
    repeat (2) @(posedge clk);
    @(negedge clk);
    probe("rst_sck", 32'(sck), 32'd0);
    probe("rst_cs", 32'(cs), 32'd1);
    probe("rst_mosi", 32'(mosi), 32'd0);
    probe("rst_busy", 32'(busy), 32'd0);
    probe("rst_start", 32'(spi_start), 32'd0);
    probe("rst_finish", 32'(spi_finish), 32'd0);
    probe("rst_dout", 32'(dout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Mode 0, 8 bits, loopback
    configure(1'b0, 1'b0, 4'd7);
    run_frame("m0", 16'h00a5, 8'd3, 16'h00a5, 16);

    // Mode 3, 16 bits, slave returns 0x3c96
    configure(1'b1, 1'b1, 4'd15);
    @(negedge clk);
    probe("idle_cpol", 32'(sck), 32'd1);
    loop = 1'b0;
    slave_word = 16'h3c96;
    run_frame("m3", 16'h1234, 8'd1, 16'h3c96, 32);

    // Single-bit frame at full speed
    configure(1'b0, 1'b0, 4'd0);
    slave_word = 16'h0000;
    run_frame("w1", 16'h0001, 8'd0, 16'h0000, 2);

    // Mid-frame start/config are ignored
    configure(1'b0, 1'b0, 4'd7);
    loop = 1'b1;
    sbq.push_back('{16'h003c, 16, 3});
    start_frame("mid", 16'h003c, 8'd2, d0);
    repeat (10) @(posedge clk);
    #1;
    start_req = 1'b1;
    din = 16'h00ff;
    config_req = 1'b1;
    config_data = {1'b1, 1'b0, 4'd3};
    @(posedge clk); #1;
    start_req = 1'b0;
    config_req = 1'b0;
    wait_done(d0, 400);
    probe("cfg_ignored", 32'(sck), 32'd0);
    run_frame("after", 16'h0081, 8'd2, 16'h0081, 16);

    // Bit order
    run_frame("order", 16'h0001, 8'd2, 16'h0001, 16);

    // Reset at the 5th sck edge
    sbq.push_back('{16'h0055, 16, 4});
    start_frame("rst", 16'h0055, 8'd3, d0);
    n = 0;
    ps = sck;
    for (int k = 0; k < 200 && n < 5; k++) begin
      @(posedge clk); #1;
      if (sck !== ps) n++;
      ps = sck;
    end
    probe("rst_edge_reach", 32'(n), 32'd5);
    rst = 1'b1;
    #1;
    probe("midrst_cs", 32'(cs), 32'd1);
    probe("midrst_sck", 32'(sck), 32'd0);
    probe("midrst_busy", 32'(busy), 32'd0);
    probe("midrst_finish", 32'(spi_finish), 32'd0);
    sbq.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tb_cpol = 1'b0;
    tb_cpha = 1'b0;
    tb_w = 4'hf;
    run_frame("post", 16'hbeef, 8'd1, 16'hbeef, 32);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_interface_master.md
Name: spi_interface_master

Overview:
SPI master-side counterpart of the slave interface: generates sck/cs, shifts din out on mosi and captures miso into dout. Runtime-configurable CPOL, CPHA and frame width (1..2**SPI_MAX_WIDTH_LOG bits) through the same config word format as the slave side. Sits between a local controller (start request/done pulses) and the off-chip SPI bus. One clock domain, sck derived by an internal divider.

Parameters:
SPI_MAX_WIDTH_LOG, 4, log2 of max frame width; data ports are 2**SPI_MAX_WIDTH_LOG bits
CLK_DIV_WIDTH, 8, width of clk_div input

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
config_req  input  1  load config_data when idle
config_data  input  SPI_MAX_WIDTH_LOG+2  [LOG+1]=cpol, [LOG]=cpha, [LOG-1:0]=spi_width (bits minus 1)
clk_div  input  CLK_DIV_WIDTH  sck half-period = clk_div+1 clk cycles; sampled at start
start_req  input  1  request one frame
din  input  2**LOG  transmit word, right-aligned, sampled at accepted start_req
busy  output  1  high from accepted start_req until spi_finish cycle inclusive
spi_start  output  1  one-cycle pulse when frame accepted
spi_finish  output  1  one-cycle pulse when frame complete, dout valid same cycle
dout  output  2**LOG  received word, right-aligned, upper bits zero
sck  output  1  SPI clock
cs  output  1  chip select, active-low
mosi  output  1  master data out
miso  input  1  slave data in (synchronous to clk externally; no synchroniser inside)

Behaviour:
- Reset: cpol=0, cpha=0, spi_width=all ones; sck=0, cs=1, mosi=0, busy=0, spi_start=0, spi_finish=0, dout=0; FSM IDLE.
- Config: config_req in IDLE registers config_data next cycle; sck immediately moves to new cpol. config_req while busy ignored. config_req and start_req same cycle: config loaded first, frame uses new config.
- FSM IDLE -> SETUP on start_req (busy=0): latch din, clk_div; spi_start pulse; cs=0 next cycle; mosi = bit spi_width of din (MSB of frame).
- SETUP: hold one half-period, sck=cpol -> TRANSFER.
- TRANSFER: sck toggles every clk_div+1 cycles; exactly 2*(spi_width+1) edges. Leading edge = first edge of each bit.
  - cpha=0: sample miso on leading, drive next mosi bit on trailing (not after last bit).
  - cpha=1: drive mosi on leading (first bit driven on first leading edge; SETUP mosi value don't-care = MSB), sample on trailing.
  - Received bits shift in LSB-side; after last sample, shift register holds frame right-aligned.
- After final edge (sck back at cpol) -> HOLD: one half-period, cs=1 asserted at HOLD entry + half-period, then spi_finish pulse, dout updated, busy drops next cycle -> IDLE.
- Back-to-back: start_req in spi_finish cycle ignored; accepted earliest cycle after.
- start_req while busy: ignored, no queueing.
- clk_div=0: sck toggles every clk cycle (sck = clk/2) — legal.
- spi_width=0: single-bit frame, 2 edges.
- rst mid-frame: immediate return to reset values, cs=1, no spi_finish.

Optional Feature:
SPI_MASTER_LSB_FIRST_EN: when defined, bit order LSB-first for both mosi (starts at din[0]) and miso (first received bit lands in dout[0], last in dout[spi_width]). Undefined: MSB-first as above. Must match slave build.

Test Plan:
- Mode 0, width 8 (config_data cpol=0,cpha=0,width=7), clk_div=3, din=0xA5, miso loopback from mosi -> 16 sck edges, half-period 4 clk, dout=0x00A5, one spi_start and one spi_finish pulse, cs low throughout.
- Mode 3 (cpol=1,cpha=1), width 16, slave model returns 0x3C96 -> sck idles high, mosi changes on falling edges, dout=0x3C96.
- Width 1 (spi_width=0), clk_div=0, din=1, miso=0 -> 2 sck edges, mosi=1, dout=0.
- start_req and config_req pulsed mid-frame -> ignored; frame completes with old config, next frame uses nothing new until re-issued.
- rst asserted at 5th sck edge -> same cycle cs=1, sck=0, busy=0, no spi_finish; following frame correct.
- With SPI_MASTER_LSB_FIRST_EN, width 8, din=0x01 -> mosi high on first bit only; loopback dout=0x01.
